// File: rtl/byte_unstriping.sv
// Merges two striped byte lanes back into one stream through a 4-entry FIFO per lane.
// Optional sticky overflow flag enabled by defining BYTE_UNSTRIPING_ERROR_EN.
module byte_unstriping (
    input  logic       clk_2f,
    input  logic       reset,
    input  logic [7:0] lane_0,
    input  logic       valid_0,
    input  logic [7:0] lane_1,
    input  logic       valid_1,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       error
);

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 2;
    localparam int unsigned CW    = 3;
    localparam int unsigned LANES = 2;

    logic [DW-1:0] mem    [LANES][DEPTH];
    logic [PW-1:0] rd_ptr [LANES];
    logic [PW-1:0] wr_ptr [LANES];
    logic [CW-1:0] count  [LANES];
    logic          sel;

    logic [DW-1:0] in_data [LANES];
    logic [1:0]    in_valid;
    logic [1:0]    full;
    logic [1:0]    pop;
    logic [1:0]    push;

    assign in_data[0] = lane_0;
    assign in_data[1] = lane_1;
    assign in_valid   = {valid_1, valid_0};

    // Only the selected lane may pop; a full FIFO still accepts a push when it pops.
    always_comb begin
        full = '0;
        pop  = '0;
        push = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            full[i] = (count[i] == CW'(DEPTH));
        end
        pop[0] = !sel && (count[0] != '0);
        pop[1] =  sel && (count[1] != '0);
        for (int i = 0; i < int'(LANES); i++) begin
            push[i] = in_valid[i] && (!full[i] || pop[i]);
        end
    end

    // Storage is not reset; pointers and counts guard every read.
    always_ff @(posedge clk_2f) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_data[i];
            end
        end
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(LANES); i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CW'(1);
                end else if (pop[i] && !push[i]) begin
                    count[i] <= count[i] - CW'(1);
                end
            end
        end
    end

    // Merge stage: an empty selected lane stalls output rather than skipping ahead.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            sel       <= 1'b0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else if (|pop) begin
            sel       <= ~sel;
            data_out  <= mem[sel][rd_ptr[sel]];
            valid_out <= 1'b1;
        end else begin
            valid_out <= 1'b0;
        end
    end

`ifdef BYTE_UNSTRIPING_ERROR_EN
    logic [1:0] drop;

    assign drop = in_valid & full & ~pop;

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            error <= 1'b0;
        end else if (|drop) begin
            error <= 1'b1;
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_byte_unstriping.sv
// Self-checking bench for byte_unstriping: vector table plus directed multi-cycle sequences,
// merged output checked against an expected-byte queue.
module tb_byte_unstriping;

    logic       clk_2f = 1'b0;
    logic       reset;
    logic [7:0] lane_0;
    logic       valid_0;
    logic [7:0] lane_1;
    logic       valid_1;
    logic [7:0] data_out;
    logic       valid_out;
    logic       error;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] sb_q [$];

`ifdef BYTE_UNSTRIPING_ERROR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct {
        logic       v0;
        logic [7:0] l0;
        logic       v1;
        logic [7:0] l1;
        logic       exp_v;
        logic [7:0] exp_d;
    } vec_t;

    vec_t tbl [15];

    byte_unstriping dut (
        .clk_2f   (clk_2f),
        .reset    (reset),
        .lane_0   (lane_0),
        .valid_0  (valid_0),
        .lane_1   (lane_1),
        .valid_1  (valid_1),
        .data_out (data_out),
        .valid_out(valid_out),
        .error    (error)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, then score any merged byte that comes out on that edge.
    task automatic step(input logic v0, input logic [7:0] l0, input logic v1, input logic [7:0] l1);
        valid_0 = v0;
        lane_0  = l0;
        valid_1 = v1;
        lane_1  = l1;
        @(posedge clk_2f);
        #1;
        valid_0 = 1'b0;
        valid_1 = 1'b0;
        if (valid_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got %0h expected no output", data_out);
            end else begin
                check("sb_data", 32'(data_out), 32'(sb_q.pop_front()));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    initial begin
        reset   = 1'b0;
        lane_0  = 8'h00;
        valid_0 = 1'b0;
        lane_1  = 8'h00;
        valid_1 = 1'b0;

        // Both lanes on two cycles, then lane_1 arriving well ahead of lane_0.
        tbl[0]  = '{1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 8'hCC, 1'b1, 8'hDD, 1'b1, 8'hAA};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hBB};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hCC};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hDD};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[11] = '{1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h22};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h11};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};

        #1;
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        @(posedge clk_2f);
        @(posedge clk_2f);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].exp_v) sb_q.push_back(tbl[i].exp_d);
            step(tbl[i].v0, tbl[i].l0, tbl[i].v1, tbl[i].l1);
            check($sformatf("tbl_valid[%0d]", i), 32'(valid_out), 32'(tbl[i].exp_v));
        end
        check("tbl_drained", 32'(sb_q.size()), 32'h0);

        // Overflow lane_1 while lane_0 is idle: the fifth byte must be dropped.
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 8'h00, 1'b1, 8'(k));
            check("ovf_stall", 32'(valid_out), 32'h0);
        end
        idle(2);
        check("ovf_error", 32'(error), 32'(EXP_ERR));
        sb_q.push_back(8'hA0); sb_q.push_back(8'h01);
        sb_q.push_back(8'hA1); sb_q.push_back(8'h02);
        sb_q.push_back(8'hA2); sb_q.push_back(8'h03);
        sb_q.push_back(8'hA3); sb_q.push_back(8'h04);
        for (int k = 0; k < 4; k++) step(1'b1, 8'hA0 + 8'(k), 1'b0, 8'h00);
        idle(7);
        check("ovf_drained", 32'(sb_q.size()), 32'h0);
        sb_q.push_back(8'hA4);
        step(1'b1, 8'hA4, 1'b0, 8'h00);
        idle(3);
        check("no_byte_05", 32'(valid_out), 32'h0);
        sb_q.push_back(8'hB5);
        step(1'b0, 8'h00, 1'b1, 8'hB5);
        idle(2);
        check("realign_drained", 32'(sb_q.size()), 32'h0);

        reset = 1'b0;
        #2;
        check("reset_clears_error", 32'(error), 32'h0);
        reset = 1'b1;

        // Alternating lanes, one byte per cycle: no gaps once the first byte appears.
        for (int i = 0; i < 64; i++) begin
            sb_q.push_back(8'(i));
            step(i % 2 == 0, 8'(i), i % 2 == 1, 8'(i));
            if (i >= 1) check($sformatf("stream_gap[%0d]", i), 32'(valid_out), 32'h1);
        end
        idle(1);
        check("stream_last", 32'(valid_out), 32'h1);
        idle(1);
        check("stream_error", 32'(error), 32'h0);
        check("stream_drained", 32'(sb_q.size()), 32'h0);

        // Buffer three bytes, reset mid-cycle, and make sure nothing stale survives.
        for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1, 8'hC0 + 8'(k));
        check("pre_reset_data", 32'(data_out), 32'h3F);
        reset   = 1'b0;
        lane_0  = 8'h77;
        valid_0 = 1'b1;
        #1;
        check("mid_rst_data", 32'(data_out), 32'h0);
        check("mid_rst_valid", 32'(valid_out), 32'h0);
        check("mid_rst_error", 32'(error), 32'h0);
        @(posedge clk_2f);
        @(posedge clk_2f);
        #1;
        check("rst_ignores_valid", 32'(valid_out), 32'h0);
        valid_0 = 1'b0;
        reset   = 1'b1;
        sb_q.push_back(8'hE0);
        sb_q.push_back(8'hE1);
        step(1'b1, 8'hE0, 1'b1, 8'hE1);
        idle(5);
        check("post_rst_drained", 32'(sb_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/byte_unstriping.md
BYTE_UNSTRIPING -- requirements
Module: byte_unstriping

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-002 Port list:
- clk_2f  input  1  sole clock; all logic on rising edge.
- reset  input  1  asynchronous active-low reset.
- lane_0  input  8  byte from stripe lane 0.
- valid_0  input  1  lane_0 holds a byte this cycle.
- lane_1  input  8  byte from stripe lane 1.
- valid_1  input  1  lane_1 holds a byte this cycle.
- data_out  output  8  merged byte stream.
- valid_out  output  1  data_out holds a byte this cycle.
- error  output  1  sticky lane overflow flag.

Function
REQ-003 The block SHALL hold one 4-entry FIFO per lane.
- Each FIFO has a 2-bit read pointer, a 2-bit write pointer and a 3-bit count (0..4).
REQ-004 A cycle with valid_N=1 SHALL write lane_N into FIFO N, unless the write is dropped under REQ-009.
REQ-005 A select bit sel SHALL name the lane to read next.
- sel resets to 0, so the first merged byte comes from lane_0, matching the stripe order.
REQ-006 When FIFO[sel] is non-empty, the block SHALL pop it in that cycle.
- data_out and valid_out are registered from the popped entry and appear on the next edge.
- sel toggles on every pop.
REQ-007 When FIFO[sel] is empty, the block SHALL:
- drive valid_out=0 on the next edge and hold data_out at its last value;
- keep sel unchanged, so lane order is never skipped even if the other FIFO holds data.
REQ-008 Latency SHALL be 2 cycles from a valid_N sample to the matching valid_out, when that lane is selected and its FIFO is empty.
- A push and a pop on the same FIFO in one cycle are both performed; count is unchanged.
REQ-009 Writing a full FIFO (count=4) with no pop on that FIFO in the same cycle SHALL drop the incoming byte.
- Stored contents stay intact.
- A push to a full FIFO that is popped in the same cycle is accepted.
REQ-010 Pointers SHALL wrap modulo 4 and count SHALL never exceed 4 or go below 0.
REQ-011 Sustained throughput SHALL be one byte per cycle when both lanes supply one byte every other cycle each, alternating.

Reset
REQ-012 While reset=0, the block SHALL immediately force, regardless of clk_2f:
- data_out=8'h00, valid_out=0, error=0;
- sel=0, and all pointers and counts to 0.
REQ-013 FIFO storage need not be cleared.
REQ-014 Assertion mid-operation SHALL discard all buffered bytes; the first byte after release comes from lane_0.
REQ-015 The block SHALL ignore valid_0/valid_1 while reset=0.

Configuration
REQ-016 Macro BYTE_UNSTRIPING_ERROR_EN:
- Defined: error sets to 1 on the edge after any dropped write (REQ-009) and holds until reset.
- Undefined: error is tied to 0 and no overflow-detection logic is built.
- Merge behaviour is identical in both builds.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Reset release, then lane_0 = 8'hAA,8'hCC and lane_1 = 8'hBB,8'hDD, both lanes valid on two consecutive cycles -> data_out AA,BB,CC,DD on consecutive cycles with valid_out=1; first byte appears 2 cycles after the first valid sample.
- lane_1=8'h11 valid alone, 5 cycles later lane_0=8'h22 valid -> valid_out stays 0 until 22 is output; then 11 follows on the next cycle.
- 5 bytes 8'h01..8'h05 into lane_1 only, lane_0 idle -> 05 dropped; with BYTE_UNSTRIPING_ERROR_EN error=1 after the fifth write, without it error=0. Then lane_0 gets 4 bytes -> output interleaves lane_0 bytes with 01,02,03,04.
- Continuous alternating traffic of 8'h00..8'h3F for 64 cycles -> output matches the input stream; error stays 0; no gaps after the initial latency.
- reset pulsed low mid-stream with 3 bytes buffered -> outputs go to 0 immediately; after release, new bytes 8'hE0 (lane_0) and 8'hE1 (lane_1) produce E0,E1 with no stale data.
